// File: rtl/transpose_buffer.sv
// transpose_buffer: accepts 8x8 byte blocks in row-major order and emits each
// block in column-major order. Output is issued in 8-byte column bursts; the
// downstream ready gates only the first beat of each column.
//
// Build option: define TRANSPOSE_PINGPONG_EN for two banks, so one block can
// fill while the other drains. Without it there is a single bank, and the
// write/read bank selects are fixed at 0.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena_in   upstream write strobe
//   in       upstream data byte (row-major)
//   rdy_out  block can accept a byte this cycle (combinational)
//   rdy_in   downstream ready to start an 8-byte column burst
//   ena_out  out carries a valid byte this cycle (combinational)
//   out      output data byte (column-major, combinational)
module transpose_buffer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_in,
    input  logic [7:0] in,
    output logic       rdy_out,
    input  logic       rdy_in,
    output logic       ena_out,
    output logic [7:0] out
);

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 6;
`ifdef TRANSPOSE_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam int unsigned AW    = IW + $clog2(NB);
    localparam int unsigned DEPTH = NB * 64;

    logic [IW-1:0] r_widx;
    logic [IW-1:0] r_ridx;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_wr;
    logic          w_rd;
    logic          w_wr_last;
    logic          w_rd_last;
    logic          w_full_wsel;
    logic          w_full_rsel;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    // Write/read handshakes; a block completes on index 63.
    assign w_wr      = ena_in && rdy_out;
    assign w_rd      = ena_out;
    assign w_wr_last = w_wr && (r_widx == IW'(63));
    assign w_rd_last = w_rd && (r_ridx == IW'(63));

    assign rdy_out = !w_full_wsel;
    // Mid-column beats (ridx[2:0] != 0) continue regardless of rdy_in.
    assign ena_out = w_full_rsel && (rdy_in || (r_ridx[2:0] != 3'd0));

`ifdef TRANSPOSE_PINGPONG_EN
    logic       r_wsel;
    logic       r_rsel;
    logic [1:0] r_full;
    logic [1:0] w_full_nxt;

    assign w_full_wsel = r_full[r_wsel];
    assign w_full_rsel = r_full[r_rsel];
    assign w_waddr     = {r_wsel, r_widx};
    // Read column ridx[5:3], row ridx[2:0] from row-major storage.
    assign w_raddr     = {r_rsel, r_ridx[2:0], r_ridx[5:3]};

    // Set and clear may land on different banks in the same cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) w_full_nxt[r_wsel] = 1'b1;
        if (w_rd_last) w_full_nxt[r_rsel] = 1'b0;
    end

    // Bank selects and full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_last) r_wsel <= ~r_wsel;
            if (w_rd_last) r_rsel <= ~r_rsel;
        end
    end
`else
    logic r_full;

    assign w_full_wsel = r_full;
    assign w_full_rsel = r_full;
    assign w_waddr     = r_widx;
    assign w_raddr     = {r_ridx[2:0], r_ridx[5:3]};

    // Single bank: write and read completion are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (w_wr_last) begin
            r_full <= 1'b1;
        end else if (w_rd_last) begin
            r_full <= 1'b0;
        end
    end
`endif

    // Write and read indices, both wrapping 63 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_widx <= '0;
            r_ridx <= '0;
        end else begin
            if (w_wr) r_widx <= r_widx + IW'(1);
            if (w_rd) r_ridx <= r_ridx + IW'(1);
        end
    end

    // Block storage, not reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_waddr] <= in;
    end

    assign out = r_mem[w_raddr];

endmodule
